timer_intc: RTL and testbench

- Memory-mapped countdown timer with interrupt generation.
- Sits on the processor data bus beside the other peripherals, selected by its own write-enable from the address decoder. Its read data feeds a read-data mux input.
- Its irq output drives the processor's ext_int input directly, making it the upstream interrupt source for the core.
- Four word registers selected by address bits [3:2].

---
 rtl/timer_intc.sv | 123 ++++++++++++
 tb/tb_timer_intc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_intc.sv
// Memory-mapped countdown timer with sticky expiry status and registered interrupt.
// Optional watchdog reset pulse on overrun when TIMER_WDT_EN is defined.
module timer_intc #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  a,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
`ifdef TIMER_WDT_EN
    ,
    output logic        wdt_rst
`endif
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic             en_q, auto_q, ie_q;
    logic [WIDTH-1:0] load_q, count_q;
    logic             exp_q, ovr_q;
    logic [PW-1:0]    presc_q;

    logic             ctrl_we, load_we, sts_we;
    logic             tick, expire;
    logic             en_next, auto_next, ie_next;
    logic             exp_next, ovr_next;
    logic [WIDTH-1:0] load_next, count_next;
    logic [PW-1:0]    presc_next;

    always_comb begin
        ctrl_we = we && (a == 2'd0);
        load_we = we && (a == 2'd1);
        sts_we  = we && (a == 2'd3);
        tick    = en_q && (presc_q == PRESC_MAX);
        // A LOAD write in the same cycle swallows the tick entirely.
        expire  = tick && !load_we && (count_q == WIDTH'(1));
    end

    always_comb begin
        en_next    = en_q;
        auto_next  = auto_q;
        ie_next    = ie_q;
        load_next  = load_q;
        count_next = count_q;
        presc_next = presc_q;

        if (expire && !auto_q)
            en_next = 1'b0;
        if (ctrl_we) begin
            en_next   = wd[0];
            auto_next = wd[1];
            ie_next   = wd[2];
        end

        if (load_we) begin
            load_next  = wd[WIDTH-1:0];
            count_next = wd[WIDTH-1:0];
        end else if (expire) begin
            count_next = auto_q ? load_q : '0;
        end else if (tick && (count_q > WIDTH'(1))) begin
            count_next = count_q - WIDTH'(1);
        end

        if (load_we || (ctrl_we && wd[0]) || !en_q || tick)
            presc_next = '0;
        else
            presc_next = presc_q + PW'(1);

        // Expiry beats a simultaneous write-1-to-clear.
        exp_next = (exp_q & ~(sts_we & wd[0])) | expire;
        ovr_next = (ovr_q & ~(sts_we & wd[1])) | (expire & exp_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            load_q  <= '0;
            count_q <= '0;
            presc_q <= '0;
            exp_q   <= 1'b0;
            ovr_q   <= 1'b0;
            irq     <= 1'b0;
        end else begin
            en_q    <= en_next;
            auto_q  <= auto_next;
            ie_q    <= ie_next;
            load_q  <= load_next;
            count_q <= count_next;
            presc_q <= presc_next;
            exp_q   <= exp_next;
            ovr_q   <= ovr_next;
            irq     <= exp_next & ie_next;
        end
    end

`ifdef TIMER_WDT_EN
    always_ff @(posedge clk) begin
        if (rst)
            wdt_rst <= 1'b0;
        else
            wdt_rst <= expire & exp_q;
    end
`endif

    always_comb begin
        rd = '0;
        case (a)
            2'd0: rd = {29'd0, ie_q, auto_q, en_q};
            2'd1: rd = 32'(load_q);
            2'd2: rd = 32'(count_q);
            2'd3: rd = {30'd0, ovr_q, exp_q};
            default: rd = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_intc.sv
// Directed self-checking bench for timer_intc: one PRESCALE=1 instance and one PRESCALE=4 instance.
module tb_timer_intc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  a = '0, a4 = '0;
    logic        we = 1'b0, we4 = 1'b0;
    logic [31:0] wd = '0, wd4 = '0;
    logic [31:0] rd, rd4;
    logic        irq, irq4;
`ifdef TIMER_WDT_EN
    logic        wdt_rst, wdt_rst4;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    timer_intc #(.WIDTH(32), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .a(a), .we(we), .wd(wd), .rd(rd), .irq(irq)
`ifdef TIMER_WDT_EN
        , .wdt_rst(wdt_rst)
`endif
    );

    timer_intc #(.WIDTH(32), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .we(we4), .wd(wd4), .rd(rd4), .irq(irq4)
`ifdef TIMER_WDT_EN
        , .wdt_rst(wdt_rst4)
`endif
    );

    task automatic do_reset;
        we = 1'b0; we4 = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        a = addr; wd = data; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wr4(input logic [1:0] addr, input logic [31:0] data);
        a4 = addr; wd4 = data; we4 = 1'b1;
        @(negedge clk);
        we4 = 1'b0;
    endtask

    task automatic rdr(input logic [1:0] addr, output logic [31:0] v);
        a = addr; #1; v = rd;
    endtask

    task automatic rdr4(input logic [1:0] addr, output logic [31:0] v);
        a4 = addr; #1; v = rd4;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rdr(2'(i), v);
            total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_reg%0d got=%0h want=0", i, v); end
            rdr4(2'(i), v);
            total++; if (v !== 32'd0) begin bad++; $display("FAIL reset4_reg%0d got=%0h want=0", i, v); end
        end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    endtask

    task automatic test_auto_reload;
        logic [31:0] v, want;
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h7);
        for (int i = 0; i <= 10; i++) begin
            want = (i % 5 == 0) ? 32'd5 : 32'(5 - (i % 5));
            rdr(2'd2, v);
            total++; if (v !== want) begin bad++; $display("FAIL auto_count[%0d] got=%0d want=%0d", i, v, want); end
            rdr(2'd3, v);
            total++; if (v[0] !== (i >= 5)) begin bad++; $display("FAIL auto_exp[%0d] got=%b want=%b", i, v[0], i >= 5); end
            total++; if (irq !== (i >= 5)) begin bad++; $display("FAIL auto_irq[%0d] got=%b want=%b", i, irq, i >= 5); end
            @(negedge clk);
        end
    endtask

    task automatic test_one_shot;
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h5);
        repeat (2) @(negedge clk);
        rdr(2'd2, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL oneshot_count1 got=%0d want=1", v); end
        @(negedge clk);
        rdr(2'd2, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL oneshot_count0 got=%0d want=0", v); end
        rdr(2'd0, v);
        total++; if (v !== 32'h4) begin bad++; $display("FAIL oneshot_ctrl got=%0h want=4", v); end
        rdr(2'd3, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL oneshot_status got=%0h want=1", v); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq got=%b want=1", irq); end
        wr(2'd2, 32'h55);
        rdr(2'd2, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL count_ro got=%0h want=0", v); end
        repeat (20) @(negedge clk);
        rdr(2'd2, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL oneshot_idle_count got=%0d want=0", v); end
        rdr(2'd3, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL oneshot_idle_status got=%0h want=1", v); end
        rdr(2'd0, v);
        total++; if (v !== 32'h4) begin bad++; $display("FAIL oneshot_idle_ctrl got=%0h want=4", v); end
    endtask

    task automatic test_w1c_race;
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h7);
        repeat (3) @(negedge clk);
        rdr(2'd2, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL race_precount got=%0d want=1", v); end
        wr(2'd3, 32'h1);
        rdr(2'd3, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL race_status got=%0h want=1", v); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL race_irq got=%b want=1", irq); end
        rdr(2'd2, v);
        total++; if (v !== 32'd4) begin bad++; $display("FAIL race_reload got=%0d want=4", v); end
        wr(2'd3, 32'h3);
        rdr(2'd3, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL clear_status got=%0h want=0", v); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL clear_irq got=%b want=0", irq); end
    endtask

    task automatic test_overrun;
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h3);
        repeat (2) @(negedge clk);
        rdr(2'd3, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL ovr_first got=%0h want=1", v); end
`ifdef TIMER_WDT_EN
        total++; if (wdt_rst !== 1'b0) begin bad++; $display("FAIL wdt_first got=%b want=0", wdt_rst); end
`endif
        repeat (2) @(negedge clk);
        rdr(2'd3, v);
        total++; if (v !== 32'h3) begin bad++; $display("FAIL ovr_second got=%0h want=3", v); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL ovr_irq_masked got=%b want=0", irq); end
`ifdef TIMER_WDT_EN
        total++; if (wdt_rst !== 1'b1) begin bad++; $display("FAIL wdt_pulse got=%b want=1", wdt_rst); end
        @(negedge clk);
        total++; if (wdt_rst !== 1'b0) begin bad++; $display("FAIL wdt_width got=%b want=0", wdt_rst); end
`endif
    endtask

    task automatic test_prescale_reload;
        logic [31:0] v;
        do_reset();
        wr4(2'd1, 32'd2);
        wr4(2'd0, 32'h3);
        repeat (7) @(negedge clk);
        rdr4(2'd3, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL ps_cyc7_status got=%0h want=0", v); end
        rdr4(2'd2, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL ps_cyc7_count got=%0d want=1", v); end
        @(negedge clk);
        rdr4(2'd3, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL ps_cyc8_status got=%0h want=1", v); end
        rdr4(2'd2, v);
        total++; if (v !== 32'd2) begin bad++; $display("FAIL ps_cyc8_count got=%0d want=2", v); end
        wr4(2'd3, 32'h1);
        wr4(2'd1, 32'd10);
        rdr4(2'd2, v);
        total++; if (v !== 32'd10) begin bad++; $display("FAIL ps_reload_count got=%0d want=10", v); end
        repeat (39) @(negedge clk);
        rdr4(2'd2, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL ps_l39_count got=%0d want=1", v); end
        rdr4(2'd3, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL ps_l39_status got=%0h want=0", v); end
        @(negedge clk);
        rdr4(2'd3, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL ps_l40_status got=%0h want=1", v); end
        rdr4(2'd2, v);
        total++; if (v !== 32'd10) begin bad++; $display("FAIL ps_l40_count got=%0d want=10", v); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_w1c_race();
        test_overrun();
        test_prescale_reload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
